// File: rtl/srv_line_prefetch_mem_if.sv
// Line-fill request/response channel plus the ROM word bus, bundled as one port.
// The slave side is the memory responder. The master side is the requester together with the ROM.
interface srv_line_prefetch_mem_if;
  logic         ext_req_i;
  logic [31:0]  ext_addr_i;
  logic         ext_rsp_o;
  logic [127:0] ext_data_o;
  logic         prefetch_hit_o;
  logic [31:0]  rom_addr_o;
  logic [31:0]  rom_data_i;

  modport master (
    output ext_req_i, ext_addr_i, rom_data_i,
    input  ext_rsp_o, ext_data_o, prefetch_hit_o, rom_addr_o
  );

  modport slave (
    input  ext_req_i, ext_addr_i, rom_data_i,
    output ext_rsp_o, ext_data_o, prefetch_hit_o, rom_addr_o
  );
endinterface

// File: rtl/srv_line_prefetch_mem.sv
// Memory-side line-fill responder.
// It assembles 128-bit lines from four combinational ROM word reads.
// After each response it prefetches the next sequential line into a one-line buffer,
// so that straight-line code gets 1-cycle hits.
module srv_line_prefetch_mem #(
  parameter bit PREFETCH_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  srv_line_prefetch_mem_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2,
    PF    = 2'd3
  } state_t;

  state_t       state;
  state_t       next_state;
  logic [27:0]  req_tag;
  logic [27:0]  fetch_tag;
  logic [27:0]  pf_tag;
  logic [27:0]  resp_tag;
  logic [1:0]   idx;
  logic [127:0] fill;
  logic [127:0] line_done;
  logic [127:0] pf_data;
  logic [127:0] ext_data_q;
  logic [31:0]  rom_addr_q;
  logic         pf_valid;
  logic         hit_q;
  logic         idle_hit;
  logic         idle_miss;
  logic         pf_abort;
  logic         pf_done;
  logic         pf_to_resp;
  logic         unused_addr_bits;

  assign req_tag          = bus.ext_addr_i[31:4];
  assign unused_addr_bits = ^bus.ext_addr_i[3:0];

  assign bus.ext_rsp_o      = (state == RESP);
  assign bus.prefetch_hit_o = (state == RESP) && hit_q;
  assign bus.ext_data_o     = ext_data_q;

  // State register; a synchronous reset returns to IDLE from any state, even mid-fill
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode, plus the action strobes that the datapath register block uses
  always_comb begin
    next_state = state;
    idle_hit   = 1'b0;
    idle_miss  = 1'b0;
    pf_abort   = 1'b0;
    pf_done    = 1'b0;
    pf_to_resp = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ext_req_i) begin
          if (pf_valid && (req_tag == pf_tag)) begin
            idle_hit   = 1'b1;
            next_state = RESP;
          end else begin
            idle_miss  = 1'b1;
            next_state = FETCH;
          end
        end
      end
      FETCH: begin
        if (idx == 2'd3) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (PREFETCH_EN) begin
          next_state = PF;
        end else begin
          next_state = IDLE;
        end
      end
      PF: begin
        if (bus.ext_req_i && (req_tag != pf_tag)) begin
          pf_abort   = 1'b1;
          next_state = FETCH;
        end else if (idx == 2'd3) begin
          pf_done = 1'b1;
          if (bus.ext_req_i) begin
            pf_to_resp = 1'b1;
            next_state = RESP;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The fourth word comes straight from the ROM in the final fill cycle, so it is merged in here
  always_comb begin
    line_done          = fill;
    line_done[127:96]  = bus.rom_data_i;
  end

  // The ROM address follows the fill counter while filling; otherwise it holds the last issued address
  always_comb begin
    case (state)
      FETCH:   bus.rom_addr_o = {2'b00, fetch_tag, idx};
      PF:      bus.rom_addr_o = {2'b00, pf_tag, idx};
      default: bus.rom_addr_o = rom_addr_q;
    endcase
  end

  // Datapath registers: fill assembly, prefetch buffer, served-line bookkeeping and output data
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= 2'd0;
      fill       <= '0;
      pf_data    <= '0;
      pf_tag     <= '0;
      pf_valid   <= 1'b0;
      fetch_tag  <= '0;
      resp_tag   <= '0;
      hit_q      <= 1'b0;
      ext_data_q <= '0;
      rom_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_miss) begin
            fetch_tag <= req_tag;
            idx       <= 2'd0;
            pf_valid  <= 1'b0;
          end
          if (idle_hit) begin
            ext_data_q <= pf_data;
            hit_q      <= 1'b1;
            resp_tag   <= pf_tag;
          end
        end
        FETCH: begin
          fill[{idx, 5'd0} +: 32] <= bus.rom_data_i;
          rom_addr_q              <= bus.rom_addr_o;
          idx                     <= idx + 2'd1;
          if (idx == 2'd3) begin
            ext_data_q <= line_done;
            hit_q      <= 1'b0;
            resp_tag   <= fetch_tag;
          end
        end
        RESP: begin
          if (PREFETCH_EN) begin
            pf_tag   <= resp_tag + 28'd1;
            idx      <= 2'd0;
            pf_valid <= 1'b0;
          end
        end
        PF: begin
          rom_addr_q <= bus.rom_addr_o;
          if (pf_abort) begin
            fetch_tag <= req_tag;
            idx       <= 2'd0;
            pf_valid  <= 1'b0;
          end else begin
            fill[{idx, 5'd0} +: 32] <= bus.rom_data_i;
            idx                     <= idx + 2'd1;
            if (pf_done) begin
              pf_data  <= line_done;
              pf_valid <= 1'b1;
            end
            if (pf_to_resp) begin
              ext_data_q <= line_done;
              hit_q      <= 1'b1;
              resp_tag   <= pf_tag;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/srv_line_prefetch_mem.md
# srv_line_prefetch_mem

Memory-side responder for the instruction-cache line-fill interface (ext_req/ext_addr → ext_rsp/ext_data).

- Serves each 128-bit line by reading four consecutive 32-bit words from the combinational reset ROM.
- After each response it speculatively fetches the next sequential line into a one-line prefetch buffer, so straight-line code hits with 1-cycle latency.
- Sits between the icache line-fill port and the ROM as an alternative to the plain memory controller.

## Interface
- PREFETCH_EN, default 1: 1 = next-line prefetch active; 0 = every request is a 4-word fetch and the PF state is never entered.
- clk  in  1  system clock (divided core clock)
- rst  in  1  synchronous, active-high reset
- ext_addr_i  in  32  byte address of requested line; bits [3:0] ignored; must be stable while ext_req_i high
- ext_req_i  in  1  line request, level; held until ext_rsp_o seen, low in the cycle after ext_rsp_o
- ext_rsp_o  out  1  one-cycle pulse: ext_data_o valid
- ext_data_o  out  128  line data; word k at bits [32k+31:32k]; holds last line until next response
- rom_addr_o  out  32  ROM word address = {line[27:0], idx[1:0]}
- rom_data_i  in  32  ROM word, combinational from rom_addr_o, sampled same cycle
- prefetch_hit_o  out  1  one-cycle pulse with ext_rsp_o when line came from prefetch buffer

## Operation
- Line tag = ext_addr_i[31:4] (28 bits). Prefetch target = last served tag + 1, modulo 2^28 (0x0FFFFFFF wraps to 0x0000000).
- Internal state: pf_tag[27:0], pf_data[127:0], pf_valid, fill word counter idx[1:0], 128-bit fill assembly register.
- IDLE:
  - req high and pf_valid and tag == pf_tag → RESP from pf_data, prefetch_hit_o = 1.
  - req high, otherwise → FETCH with idx = 0, pf_valid cleared.
  - req low → stay.
- FETCH:
  - Each cycle drives rom_addr_o = {tag, idx} and captures rom_data_i into word idx; idx increments.
  - After idx = 3 → RESP with the assembled line.
- RESP (1 cycle):
  - ext_rsp_o = 1; ext_data_o updated on entry.
  - Next state PF if PREFETCH_EN, else IDLE.
- PF:
  - Fetches words of tag + 1 into pf_data exactly as FETCH does; pf_tag set on entry.
  - On idx = 3 completion: pf_valid = 1, next IDLE.
  - If ext_req_i is high during PF and its tag == pf_tag: continue; on completion go directly to RESP with the fetched line, prefetch_hit_o = 1.
  - If ext_req_i is high during PF and its tag differs: abort at the next edge, pf_valid = 0, → FETCH for the requested tag with idx = 0.
- rom_addr_o in IDLE/RESP holds its last value (0 after reset).
- A request is never dropped or served twice. Each request high in IDLE/PF gets exactly one ext_rsp_o.

## Timing
- Reset values: state IDLE, ext_rsp_o 0, ext_data_o 0, rom_addr_o 0, prefetch_hit_o 0, pf_valid 0, idx 0.
- Reset is synchronous and overrides everything, including mid-FETCH/PF. No response is issued for an in-flight request.
- Miss: req sampled high in IDLE at cycle 0 → FETCH cycles 1–4 → ext_rsp_o high in cycle 5 (latency 5).
- Hit: req sampled in IDLE at cycle 0 → ext_rsp_o high in cycle 1.
- Prefetch after RESP: PF occupies 4 cycles (RESP+1 .. RESP+4); pf_valid is high from RESP+5.
- Request for prefetched line arriving in PF cycle j (1..4) → ext_rsp_o in cycle RESP+5.
- Request for another line arriving in PF cycle j → FETCH starts at cycle j+1 → ext_rsp_o at j+5.
- ext_req_i sampled only in IDLE and PF. In RESP it is ignored; the requester has it low in RESP+1.

## Test plan
- Reset then req to 0x00000000, ROM word n = n → rsp at cycle 5, data 0x00000003_00000002_00000001_00000000, prefetch_hit_o 0.
- Sequential: after line 0, wait 6 cycles, req 0x00000010 → rsp in 1 cycle, data {7,6,5,4}, prefetch_hit_o 1.
- Req 0x00000010 issued in second PF cycle → no restart; rsp exactly when prefetch completes, data {7,6,5,4}, hit pulse.
- Jump: req 0x00000100 during PF of line 1 → PF aborted, 5-cycle fetch, data {0x43,0x42,0x41,0x40}; a later req 0x10 misses (5 cycles).
- Wrap: serve 0xFFFFFFF0 → PF fetches ROM words 0..3 (rom_addr_o 0..3); req 0x00000000 hits in 1 cycle.
- Assert rst in FETCH idx 2 and in PF → no ext_rsp_o, outputs 0, pf_valid 0; with PREFETCH_EN = 0 every request takes 5 cycles and prefetch_hit_o stays 0.
